vx_csr_io_arb: RTL
==================

# vx_csr_io_arb

Round-robin arbiter and sequencer that shares the core pipeline's single CSR I/O request/response port among `NUM_REQS` host-side requesters (for example the AFU command path and the debug scope). It sits between the requesters and the pipeline's `csr_io_req_*`/`csr_io_rsp_*` ports. It keeps at most one transaction in flight and routes each read response back to the requester that issued it.

## Interface
- `NUM_REQS`, default 2: number of requesters; must be ≥2.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles; used only with `VX_CSR_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQS`: per-requester request valid.
- `req_rw` in `NUM_REQS`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQS`×12: CSR address.
- `req_data` in `NUM_REQS`×32: write data.
- `req_ready` out `NUM_REQS`: request accepted this cycle.
- `rsp_valid` out `NUM_REQS`: read response valid, one-hot.
- `rsp_data` out 32: shared read response data.
- `rsp_ready` in `NUM_REQS`: per-requester response ready.
- `csr_io_req_valid`, `csr_io_req_rw`, `csr_io_req_addr[11:0]`, `csr_io_req_data[31:0]` out: request to the pipeline.
- `csr_io_req_ready` in 1: pipeline accepts the request.
- `csr_io_rsp_valid` in 1, `csr_io_rsp_data` in 32: pipeline response.
- `csr_io_rsp_ready` out 1: arbiter accepts the response.
- `timeout_err` out 1: sticky watchdog flag; tied 0 when the feature is out.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, RETURN. Reset state is IDLE.
- IDLE:
  - Winner = first valid requester at or after `rr_ptr`, searching with wrap-around.
  - `req_ready[winner]` = 1, combinational from `req_valid` and `rr_ptr`; all other bits are 0.
  - On grant: latch rw/addr/data/owner, set `rr_ptr` = winner+1 (mod `NUM_REQS`), go to ISSUE.
- ISSUE: `csr_io_req_*` is driven from the latched registers with valid = 1. On `csr_io_req_ready`, a write goes to IDLE and a read goes to WAIT_RSP.
- WAIT_RSP: `csr_io_rsp_ready` = 1. On `csr_io_rsp_valid`, latch the data and go to RETURN.
- RETURN: `rsp_valid[owner]` = 1 and `rsp_data` = latched data. On `rsp_ready[owner]`, go to IDLE.
- Writes never produce a requester response.
- Latched request fields and `rsp_data` hold stable while their valid is high.
- Fairness: a requester that holds `req_valid` is granted within `NUM_REQS` grants.
- Simultaneous valids in IDLE: exactly one grant, per the pointer.
- `req_valid` dropped before a grant: no effect.
- Reset mid-transaction: the FSM aborts to IDLE and the in-flight transaction is lost.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `csr_io_req_valid`, `csr_io_rsp_ready`, `timeout_err`, `rr_ptr` = 0.
  - `rsp_data` and `csr_io_req_addr`/`csr_io_req_data`/`csr_io_req_rw` = 0.
- Grant happens in cycle N. `csr_io_req_valid` is high from cycle N+1.
- Write with pipeline ready at N+1: IDLE at N+2. Back-to-back write throughput is one per 2 cycles.
- Read with response at N+2 (the earliest possible): `rsp_valid` high at N+3, IDLE at N+4 if `rsp_ready` is held high.
- The arbiter adds no combinational path from `csr_io_*` inputs to requester outputs, except `req_ready` from `req_valid`.

## Configuration
- `VX_CSR_ARB_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES)`-bit counter clears on entry to WAIT_RSP and increments each cycle in that state.
  - If the count reaches `TIMEOUT_CYCLES`-1 with no response: latch `rsp_data` = 32'hDEAD_BEEF, set `timeout_err` (sticky until reset), go to RETURN.
  - `csr_io_rsp_ready` is also 1 in IDLE. Late responses that arrive in IDLE are discarded.
- `VX_CSR_ARB_TIMEOUT_EN` undefined: no counter; WAIT_RSP waits indefinitely; `timeout_err` = 0.

## Structure
- Shared package `vx_csr_arb_pkg` holds:
  - the state enum (2 bits);
  - `CSR_ARB_ERR_DATA` = 32'hDEAD_BEEF;
  - the owner index width, `$clog2(NUM_REQS)`.
- Sub-module `vx_rr_arbiter` (parameter `NUM_REQS`): takes the valid vector and `rr_ptr`, and outputs a one-hot grant plus the grant index. It is purely combinational; the pointer register stays in the parent.

## Test plan
- Reset held low mid-read, then released → all outputs 0, FSM in IDLE, the next request is granted normally.
- Req0 writes addr 12'h7C0 data 32'h1234 with pipeline ready → `csr_io_req` valid for 1 cycle with exact fields, no `rsp_valid`, IDLE 2 cycles after the grant.
- Req1 reads addr 12'hCC0; the pipeline returns 32'hCAFE_F00D 3 cycles after accept → only `rsp_valid[1]` rises, with that data. With `rsp_ready[1]`=0 for 4 cycles, `rsp_valid[1]` and `rsp_data` hold stable.
- Both requesters valid continuously for 8 writes → grants alternate 0,1,0,1,…; each `req_ready` is one-hot.
- `csr_io_req_ready` held 0 for 5 cycles in ISSUE → the request fields are stable and no new grant occurs.
- With `VX_CSR_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, a read gets no response → `rsp_data` = 32'hDEAD_BEEF 16 cycles after entering WAIT_RSP and `timeout_err` = 1. A late response in IDLE is dropped.

Source files
------------

// File: rtl/vx_csr_arb_pkg.sv
// vx_csr_arb_pkg: shared types/constants for the CSR I/O arbiter.
// Optional watchdog is enabled by defining VX_CSR_ARB_TIMEOUT_EN.
package vx_csr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RETURN   = 2'd3
  } csr_arb_state_e;

  localparam logic [31:0] CSR_ARB_ERR_DATA = 32'hDEAD_BEEF;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: combinational round-robin pick.
// First valid at or after ptr wins, with wrap-around.
module vx_rr_arbiter
  import vx_csr_arb_pkg::*;
#(
  parameter  int NUM_REQS = 2,
  localparam int OW       = owner_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [OW-1:0]       ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [OW-1:0]       grant_idx,
  output logic                grant_any
);

  // scan from the pointer, first hit wins
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (!grant_any && valid[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = OW'(j);
      end
    end
  end

endmodule

// File: rtl/vx_csr_io_arb.sv
// vx_csr_io_arb: shares one CSR I/O port among NUM_REQS requesters.
// Optional watchdog: define VX_CSR_ARB_TIMEOUT_EN.
module vx_csr_io_arb
  import vx_csr_arb_pkg::*;
#(
  parameter int NUM_REQS       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS-1:0]       req_rw,
  input  logic [NUM_REQS-1:0][11:0] req_addr,
  input  logic [NUM_REQS-1:0][31:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic [NUM_REQS-1:0]       rsp_valid,
  output logic [31:0]               rsp_data,
  input  logic [NUM_REQS-1:0]       rsp_ready,
  output logic                      csr_io_req_valid,
  output logic                      csr_io_req_rw,
  output logic [11:0]               csr_io_req_addr,
  output logic [31:0]               csr_io_req_data,
  input  logic                      csr_io_req_ready,
  input  logic                      csr_io_rsp_valid,
  input  logic [31:0]               csr_io_rsp_data,
  output logic                      csr_io_rsp_ready,
  output logic                      timeout_err
);

  localparam int OW = owner_w(NUM_REQS);

  if (NUM_REQS < 2) begin : g_bad_reqs
    $error("vx_csr_io_arb: NUM_REQS must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("vx_csr_io_arb: TIMEOUT_CYCLES must be >= 2");
  end

  csr_arb_state_e state, state_n;

  logic [OW-1:0]       rr_ptr;
  logic [OW-1:0]       owner;
  logic                rw_q;
  logic [11:0]         addr_q;
  logic [31:0]         data_q;
  logic [31:0]         rsp_q;
  logic [NUM_REQS-1:0] grant;
  logic [OW-1:0]       grant_idx;
  logic                grant_any;
  logic                take_grant;
  logic                take_rsp;
  logic                to_hit;
  logic                to_expire;
  logic                idle_drain;

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef VX_CSR_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] to_cnt;
  logic          to_err_q;

  assign to_expire   = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  // late responses are drained in IDLE; held off while in reset
  assign idle_drain  = reset;
  assign timeout_err = to_err_q;

  // watchdog counts only while waiting; error flag is sticky
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state != ST_WAIT_RSP) to_cnt <= '0;
      else                      to_cnt <= to_cnt + 1'b1;
      if (to_hit) to_err_q <= 1'b1;
    end
  end
`else
  assign to_expire   = 1'b0;
  assign idle_drain  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n          = state;
    take_grant       = 1'b0;
    take_rsp         = 1'b0;
    to_hit           = 1'b0;
    req_ready        = '0;
    rsp_valid        = '0;
    csr_io_req_valid = 1'b0;
    csr_io_rsp_ready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready        = grant;
        csr_io_rsp_ready = idle_drain;
        if (grant_any) begin
          take_grant = 1'b1;
          state_n    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        csr_io_req_valid = 1'b1;
        if (csr_io_req_ready)
          state_n = rw_q ? ST_IDLE : ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        csr_io_rsp_ready = 1'b1;
        if (csr_io_rsp_valid) begin
          take_rsp = 1'b1;
          state_n  = ST_RETURN;
        end else if (to_expire) begin
          to_hit  = 1'b1;
          state_n = ST_RETURN;
        end
      end
      ST_RETURN: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // latch granted request, pointer and response data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      owner  <= '0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rsp_q  <= '0;
    end else begin
      if (take_grant) begin
        owner  <= grant_idx;
        rr_ptr <= (grant_idx == OW'(NUM_REQS - 1)) ?
                  '0 : grant_idx + 1'b1;
        rw_q   <= req_rw[grant_idx];
        addr_q <= req_addr[grant_idx];
        data_q <= req_data[grant_idx];
      end
      if (take_rsp)    rsp_q <= csr_io_rsp_data;
      else if (to_hit) rsp_q <= CSR_ARB_ERR_DATA;
    end
  end

  assign csr_io_req_rw   = rw_q;
  assign csr_io_req_addr = addr_q;
  assign csr_io_req_data = data_q;
  assign rsp_data        = rsp_q;

endmodule
